ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver with a scan-code FIFO.
- Sits directly upstream of the MuxKey-based scan-code/7-segment decode stage and supplies its 8-bit key input.
- Synchronises the external ps2_clk/ps2_data pair, deframes 11-bit PS/2 frames, checks framing, and buffers bytes.
- Output side is a ready/pop handshake.

Parameters:
- DEPTH, 8, FIFO entries; power of two, min 2.
- TIMEOUT, 5000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ps2_clk  in  1  keyboard clock, asynchronous to clk
- ps2_data  in  1  keyboard data, asynchronous to clk
- nextdata_n  in  1  pop request, active low
- data  out  8  FIFO head byte
- ready  out  1  FIFO non-empty
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse on a rejected frame

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all state clears.
  - Pointers = 0, bit count = 0, timeout counter = 0.
  - Sync flops = 3'b111 (idle high).
  - data = 8'h00, ready = 0, overflow = 0, frame_err = 0.
- Synchroniser: 3-flop shift register on ps2_clk, 2-flop on ps2_data.
  - Falling edge detect = previous synced value 1 and current synced value 0.
  - One-cycle strobe fall_stb.
- Bit capture: on fall_stb, shift synced ps2_data into a 10-bit shift register, LSB-first order.
  - bit_cnt 0..10 increments on each fall_stb.
- Frame completion: on fall_stb with bit_cnt == 10 (11th bit), evaluate:
  - start bit == 0,
  - stop bit (current sample) == 1,
  - parity check (see Optional Feature).
- Frame pass: byte is pushed into the FIFO on the next clk edge. bit_cnt returns to 0.
- Frame fail: no push, frame_err = 1 for exactly one cycle, bit_cnt = 0.
- Timeout: counter clears on every fall_stb and whenever bit_cnt == 0.
  - Reaching TIMEOUT-1 with bit_cnt != 0 sets bit_cnt = 0 and discards the partial frame.
  - No frame_err on timeout.
- FIFO: DEPTH entries; write and read pointers of log2(DEPTH)+1 bits, wrapping naturally.
  - empty = pointers equal; full = MSBs differ and the rest are equal.
  - ready = !empty (combinational from registered pointers).
  - data = mem[rd_ptr] (combinational read of registered storage).
- Pop: every clk cycle with nextdata_n == 0 and ready == 1 advances rd_ptr by one.
  - nextdata_n low while empty has no effect.
  - Level-sensitive: holding nextdata_n low for N cycles pops up to N bytes.
- Push when not full: write mem[wr_ptr], increment wr_ptr.
- Push when full and no pop in the same cycle: byte dropped, overflow = 1 (cleared only by rst).
- Push and pop in the same cycle:
  - Both occur.
  - When full, this is not an overflow; occupancy is unchanged.
  - When empty with one entry arriving, the pop is ignored (ready was 0) and only the push occurs.
- Latency: byte visible on data with ready = 1 at most 5 clk cycles after the 11th ps2_clk falling edge at the pins.
  - Breakdown: 3 sync + 1 detect + 1 push.
- Reset mid-frame or mid-FIFO: all state discarded immediately (asynchronous). The next frame is received cleanly only from its start bit.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: frame valid only if XOR of the 8 data bits and the parity bit == 1 (odd parity); otherwise rejected with a frame_err pulse.
- Undefined: parity bit is captured but ignored. Only start/stop are checked.

Test Plan:
- Send frame for 0x1C: start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1 -> within 5 cycles ready = 1, data = 8'h1C; pulse nextdata_n low 1 cycle -> ready = 0.
- Same frame with parity 1, PS2_PARITY_CHECK_EN defined -> frame_err pulses once, ready stays 0. Macro undefined -> data = 8'h1C.
- DEPTH = 8: send 0x01..0x09 with no pop -> overflow = 1, data = 8'h01. Popping 8 times yields 0x01..0x08, then ready = 0.
- FIFO full; 9th frame's push cycle coincides with nextdata_n = 0 -> overflow stays 0, pops return 0x02..0x09.
- Send 5 bits, idle > TIMEOUT cycles, then full frame 0xF0 -> only 0xF0 received, frame_err never pulses.
- Assert rst after bit 6 of a frame holding 3 queued bytes -> ready = 0, data = 0 immediately. A following 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, deframe 11-bit frames, queue bytes in a DEPTH-entry FIFO.
// Define PS2_PARITY_CHECK_EN to also reject frames whose odd parity is wrong.
module ps2_kbd_rx #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          fall_stb_q;
    logic [9:0]    shreg_q;
    logic [3:0]    bit_cnt_q;
    logic [TW-1:0] tmo_q;
    logic          push_q;
    logic [7:0]    push_byte_q;
    logic          frame_err_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [DEPTH];
    logic          overflow_q;

    logic frame_ok_d;
    logic parity_ok_d;
    logic pop_d;
    logic full_d;

    // ---- synchroniser and falling-edge strobe ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
            fall_stb_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            fall_stb_q <= clk_sync_q[2] & ~clk_sync_q[1];
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok_d = ^shreg_q[9:1];
`else
    assign parity_ok_d = 1'b1;
`endif

    // shreg_q[0] is the start bit; the current sample is the stop bit
    assign frame_ok_d = ~shreg_q[0] & dat_sync_q[1] & parity_ok_d;

    // ---- deframer with inter-edge timeout ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall_stb_q) begin
                tmo_q   <= '0;
                shreg_q <= {dat_sync_q[1], shreg_q[9:1]};
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= '0;
                    if (frame_ok_d) begin
                        push_q      <= 1'b1;
                        push_byte_q <= shreg_q[8:1];
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q == 4'd0) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_q <= '0;
                tmo_q     <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    // ---- scan-code FIFO ----
    assign ready  = (wr_ptr_q != rd_ptr_q);
    assign full_d = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_d  = ~nextdata_n & ready;
    assign data   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (pop_d) rd_ptr_q <= rd_ptr_q + 1'b1;
            // a pop in the same cycle frees the slot being written
            if (push_q) begin
                if (!full_d || pop_d) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= push_byte_q;
                    wr_ptr_q                <= wr_ptr_q + 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus randomized frames vs a queue model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;
    localparam int HALF    = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;

    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_ferr;

    always #5 clk = ~clk;

    ps2_kbd_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    // counts cycles frame_err is high, so a stretched pulse shows up as an extra count
    always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {stop, par, b, 1'b0};
    endfunction

    // ---- reference model: frames decided from the frame rules, FIFO as a bounded queue ----
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        if (!stop || (PAR_EN && bad_par)) m_ferr++;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_fall_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_rise();
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_fall_bit(f[i]);
            ps2_rise();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        send_bits(mk(b, bad_par, stop), 11);
        ps2_data = 1'b1;
        wait_clk(8);
        model_frame(b, bad_par, stop);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ready"}, {31'd0, ready}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) chk({tag, ".data"}, {24'd0, data}, {24'd0, mq[0]});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
        chk({tag, ".frame_err_cycles"}, ferr_cnt, m_ferr);
    endtask

    task automatic pop_one(input string tag);
        if (mq.size() != 0) chk({tag, ".head"}, {24'd0, data}, {24'd0, mq[0]});
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  rb;
        int          kind;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        m_ovf = 1'b0; m_ferr = 0;
        wait_clk(3);
        chk("reset.data", {24'd0, data}, 32'h00);
        chk("reset.ready", {31'd0, ready}, 32'd0);
        chk("reset.overflow", {31'd0, overflow}, 32'd0);
        chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        wait_clk(2);

        // 0x1C with correct parity; byte visible within 5 clocks of the last falling edge
        f = mk(8'h1C, 1'b0, 1'b1);
        chk("mk1C.parity", {31'd0, f[9]}, 32'd0);
        send_bits(f, 10);
        ps2_fall_bit(f[10]);
        wait_clk(5);
        chk("lat.ready", {31'd0, ready}, 32'd1);
        chk("lat.data", {24'd0, data}, 32'h1C);
        ps2_rise();
        ps2_data = 1'b1;
        model_frame(8'h1C, 1'b0, 1'b1);
        pop_one("lat.pop");
        wait_clk(1);
        chk("lat.empty", {31'd0, ready}, 32'd0);

        // same byte with parity bit flipped
        send_frame(8'h1C, 1'b1, 1'b1);
        check_state("badpar");
        while (mq.size() != 0) pop_one("badpar.drain");
        check_state("badpar.drained");

        // overflow: nine bytes into eight slots
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
        check_state("ovf");
        chk("ovf.sticky", {31'd0, overflow}, 32'd1);
        for (int i = 1; i <= 8; i++) pop_one($sformatf("ovf.pop%0d", i));
        check_state("ovf.drained");
        do_reset();
        check_state("ovf.reset");

        // push into a full FIFO in the same cycle as a pop
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1);
        check_state("coin.full");
        f = mk(8'h09, 1'b0, 1'b1);
        send_bits(f, 10);
        ps2_fall_bit(f[10]);
        repeat (4) @(posedge clk);
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        ps2_rise();
        ps2_data = 1'b1;
        void'(mq.pop_front());
        mq.push_back(8'h09);
        wait_clk(4);
        check_state("coin");
        for (int i = 2; i <= 9; i++) pop_one($sformatf("coin.pop%0d", i));
        check_state("coin.drained");

        // partial frame abandoned by timeout
        send_bits(mk(8'hA5, 1'b0, 1'b1), 5);
        wait_clk(TIMEOUT + 20);
        send_frame(8'hF0, 1'b0, 1'b1);
        check_state("tmo");
        chk("tmo.count", mq.size(), 32'd1);
        pop_one("tmo.pop");

        // asynchronous reset in the middle of a frame with bytes queued
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 1'b1);
        check_state("rstmid.pre");
        send_bits(mk(8'h3C, 1'b0, 1'b1), 6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.ready", {31'd0, ready}, 32'd0);
        chk("rstmid.data", {24'd0, data}, 32'h00);
        wait_clk(2);
        rst = 1'b0;
        ps2_data = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        wait_clk(2);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_state("rstmid.post");
        pop_one("rstmid.pop");

        // randomized frames and pops against the model
        for (int n = 0; n < 30; n++) begin
            rb   = 8'($urandom);
            kind = $urandom_range(0, 9);
            send_frame(rb, kind == 1, kind != 0);
            check_state($sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) pop_one($sformatf("rnd%0d.pop", n));
        end
        while (mq.size() != 0) pop_one("rnd.drain");
        check_state("rnd.end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
